// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch controller: state encoding,
// the NOP injected on misaligned fetches, and the default reset PC.
package ifu_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_EXEC  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_REQ   = ST_REQ,
    S_WAIT  = ST_WAIT,
    S_ISSUE = ST_ISSUE,
    S_EXEC  = ST_EXEC
  } state_t;

  localparam logic [31:0] NOP_INST          = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RST_VALUE = 32'h8000_0000;

endpackage

// File: rtl/ifu_perf_cnt.sv
// Fetch and stall event counters; both count one per enabled cycle and wrap at 2^32.
// Purely observational: no effect on the fetch pipeline.
module ifu_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (fetch_inc) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall_inc) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer owning the PC: request -> response -> issue -> commit; inst_valid 2 cycles after request handshake.
// Every stage holds its outputs until its handshake completes. IFU_PERF_CNT_EN adds perf counters.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int                  BITWIDTH  = 32,
  parameter logic [BITWIDTH-1:0] RST_VALUE = BITWIDTH'(DEFAULT_RST_VALUE)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ifu_req_valid,
  input  logic                ifu_req_ready,
  output logic [BITWIDTH-1:0] ifu_req_addr,
  input  logic                ifu_resp_valid,
  output logic                ifu_resp_ready,
  input  logic [BITWIDTH-1:0] ifu_resp_data,
  input  logic                ifu_resp_err,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [BITWIDTH-1:0] inst,
  output logic [BITWIDTH-1:0] inst_pc,
  output logic                inst_fault,
  input  logic                commit_valid,
  input  logic [BITWIDTH-1:0] next_pc,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt,
`endif
  output logic [BITWIDTH-1:0] pc
);

  state_t              state_q, state_d;
  logic [BITWIDTH-1:0] pc_q;
  logic [BITWIDTH-1:0] inst_q, inst_d;
  logic                fault_q, fault_d;
  logic                inst_load;
  logic                pc_load;
  logic                misaligned;

  assign misaligned = (pc_q[1:0] != 2'b00);

  always_comb begin
    state_d        = state_q;
    ifu_req_valid  = 1'b0;
    ifu_resp_ready = 1'b0;
    inst_valid     = 1'b0;
    inst_load      = 1'b0;
    inst_d         = inst_q;
    fault_d        = fault_q;
    pc_load        = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (misaligned) begin
          // Misaligned PC never reaches memory; a faulting NOP is issued instead.
          inst_load = 1'b1;
          inst_d    = BITWIDTH'(NOP_INST);
          fault_d   = 1'b1;
          state_d   = S_ISSUE;
        end else begin
          ifu_req_valid = 1'b1;
          if (ifu_req_ready) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        ifu_resp_ready = 1'b1;
        if (ifu_resp_valid) begin
          inst_load = 1'b1;
          inst_d    = ifu_resp_err ? '0 : ifu_resp_data;
          fault_d   = ifu_resp_err;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        inst_valid = 1'b1;
        if (inst_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (commit_valid) begin
          pc_load = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RST_VALUE;
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pc_load) pc_q <= next_pc;
      if (inst_load) begin
        inst_q  <= inst_d;
        fault_q <= fault_d;
      end
    end
  end

  assign ifu_req_addr = pc_q;
  assign inst_pc      = pc_q;
  assign pc           = pc_q;
  assign inst         = inst_q;
  assign inst_fault   = fault_q;

`ifdef IFU_PERF_CNT_EN
  logic fetch_inc;
  logic stall_inc;

  assign fetch_inc = (state_q == S_WAIT) && ifu_resp_valid;
  assign stall_inc = ((state_q == S_REQ) && !ifu_req_ready) ||
                     ((state_q == S_WAIT) && !ifu_resp_valid);

  ifu_perf_cnt u_perf_cnt (
    .clk       (clk),
    .rst       (rst),
    .fetch_inc (fetch_inc),
    .stall_inc (stall_inc),
    .fetch_cnt (perf_fetch_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed self-checking bench for ifu_fetch_ctrl; perf counter checks only when IFU_PERF_CNT_EN is defined.
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready;
  logic [31:0] ifu_resp_data;
  logic        ifu_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        commit_valid;
  logic [31:0] next_pc;
  logic [31:0] pc;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  ifu_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_ready (ifu_resp_ready),
    .ifu_resp_data  (ifu_resp_data),
    .ifu_resp_err   (ifu_resp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .commit_valid   (commit_valid),
    .next_pc        (next_pc),
`ifdef IFU_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .pc             (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1;
    ifu_req_ready = 1'b0; ifu_resp_valid = 1'b0; ifu_resp_data = '0; ifu_resp_err = 1'b0;
    inst_ready = 1'b0; commit_valid = 1'b0; next_pc = '0;

    // Reset state
    #12;
    chk("rst_req_valid", {31'd0, ifu_req_valid}, 32'd0);
    chk("rst_resp_ready", {31'd0, ifu_resp_ready}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_fault", {31'd0, inst_fault}, 32'd0);
    chk("rst_pc", pc, 32'h8000_0000);
    rst = 1'b0; ifu_req_ready = 1'b1;
    #1;
    chk("idle_no_req", {31'd0, ifu_req_valid}, 32'd0);

    // Normal fetch
    step();
    chk("req_valid_first", {31'd0, ifu_req_valid}, 32'd1);
    chk("req_addr_first", ifu_req_addr, 32'h8000_0000);
    step();
    ifu_req_ready = 1'b0;
    chk("wait_resp_ready", {31'd0, ifu_resp_ready}, 32'd1);
    chk("wait_no_req", {31'd0, ifu_req_valid}, 32'd0);
    ifu_resp_valid = 1'b1; ifu_resp_data = 32'h0050_0093;
    step();
    ifu_resp_valid = 1'b0;
    chk("issue_valid", {31'd0, inst_valid}, 32'd1);
    chk("issue_inst", inst, 32'h0050_0093);
    chk("issue_pc", inst_pc, 32'h8000_0000);
    chk("issue_fault", {31'd0, inst_fault}, 32'd0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("exec_no_valid", {31'd0, inst_valid}, 32'd0);
    commit_valid = 1'b1; next_pc = 32'h8000_0004;
    step();
    commit_valid = 1'b0;
    chk("seq_req_valid", {31'd0, ifu_req_valid}, 32'd1);
    chk("seq_req_addr", ifu_req_addr, 32'h8000_0004);
    chk("seq_pc", pc, 32'h8000_0004);

    // Request backpressure for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_req_valid", {31'd0, ifu_req_valid}, 32'd1);
      chk("bp_req_addr", ifu_req_addr, 32'h8000_0004);
      chk("bp_no_resp_ready", {31'd0, ifu_resp_ready}, 32'd0);
    end
`ifdef IFU_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt, 32'd3);
    chk("perf_fetch", perf_fetch_cnt, 32'd1);
`endif
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    chk("bp_single_hs", {31'd0, ifu_req_valid}, 32'd0);
    ifu_resp_valid = 1'b1; ifu_resp_data = 32'h00A0_0113;
    step();
    ifu_resp_valid = 1'b0;
    // Issue backpressure with spurious commit pulses that must be ignored
    for (int i = 0; i < 2; i++) begin
      commit_valid = 1'b1; next_pc = 32'hDEAD_BEE0;
      step();
      commit_valid = 1'b0;
      chk("ibp_valid", {31'd0, inst_valid}, 32'd1);
      chk("ibp_inst", inst, 32'h00A0_0113);
      chk("ibp_pc", inst_pc, 32'h8000_0004);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;

    // Trap redirect
    commit_valid = 1'b1; next_pc = 32'h8000_1000;
    step();
    commit_valid = 1'b0;
    chk("trap_req_addr", ifu_req_addr, 32'h8000_1000);
    chk("trap_req_valid", {31'd0, ifu_req_valid}, 32'd1);

    // Stale response in REQ is ignored
    ifu_resp_valid = 1'b1; ifu_resp_data = 32'h1111_1111;
    step();
    ifu_resp_valid = 1'b0;
    chk("stale_no_inst", {31'd0, inst_valid}, 32'd0);
    chk("stale_still_req", {31'd0, ifu_req_valid}, 32'd1);

    // Bus error
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    ifu_resp_valid = 1'b1; ifu_resp_err = 1'b1; ifu_resp_data = 32'hFFFF_FFFF;
    step();
    ifu_resp_valid = 1'b0; ifu_resp_err = 1'b0;
    chk("err_inst", inst, 32'd0);
    chk("err_fault", {31'd0, inst_fault}, 32'd1);
    chk("err_pc", inst_pc, 32'h8000_1000);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;

    // Misaligned PC
    commit_valid = 1'b1; next_pc = 32'h8000_0002;
    step();
    commit_valid = 1'b0;
    chk("mis_no_req", {31'd0, ifu_req_valid}, 32'd0);
    chk("mis_pc", pc, 32'h8000_0002);
    step();
    chk("mis_valid", {31'd0, inst_valid}, 32'd1);
    chk("mis_inst", inst, 32'h0000_0013);
    chk("mis_fault", {31'd0, inst_fault}, 32'd1);
    chk("mis_inst_pc", inst_pc, 32'h8000_0002);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;

    // Top-of-space PC
    commit_valid = 1'b1; next_pc = 32'hFFFF_FFFC;
    step();
    commit_valid = 1'b0;
    chk("top_req_valid", {31'd0, ifu_req_valid}, 32'd1);
    chk("top_req_addr", ifu_req_addr, 32'hFFFF_FFFC);

    // Async reset while waiting for a response
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    chk("pre_rst_wait", {31'd0, ifu_resp_ready}, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("arst_resp_ready", {31'd0, ifu_resp_ready}, 32'd0);
    chk("arst_req_valid", {31'd0, ifu_req_valid}, 32'd0);
    chk("arst_pc", pc, 32'h8000_0000);
    chk("arst_inst", inst, 32'd0);
    ifu_resp_valid = 1'b1; ifu_resp_data = 32'h1234_5678;
    #2 rst = 1'b0;
    step();
    step();
    chk("late_no_inst", {31'd0, inst_valid}, 32'd0);
    chk("late_req_valid", {31'd0, ifu_req_valid}, 32'd1);
    chk("late_req_addr", ifu_req_addr, 32'h8000_0000);
    ifu_resp_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
